// File: rtl/operate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operate_pkg
// Description : Shared constants and types for the operate verifier:
//               operate codes, game-state stop pattern, target indices,
//               target-class enum and item indices.
// Revision    : 1.0 - initial clocked verifier release
// ============================================================================
package operate_pkg;

  // Operate codes as issued by the UART command decoder
  localparam logic [7:0] OP_GET      = 8'h86;
  localparam logic [7:0] OP_PUT      = 8'h8A;
  localparam logic [7:0] OP_INTERACT = 8'h92;
  localparam logic [7:0] OP_MOVE     = 8'hA2;
  localparam logic [7:0] OP_THROW    = 8'hC2;
  localparam logic [7:0] OP_IGNORE   = 8'h82;

  // data_game_state[3:2] pattern meaning the game is stopped
  localparam logic [1:0] GAME_STATE_STOP = 2'b10;

  // Target indices (storages occupy 1..STORAGE_END, parameterised elsewhere)
  localparam int unsigned TGT_NONE      = 0;
  localparam int unsigned TGT_PROC_A_0  = 7;
  localparam int unsigned TGT_PROC_A_1  = 8;
  localparam int unsigned TGT_TABLE_0   = 9;
  localparam int unsigned TGT_PROC_B_0  = 10;
  localparam int unsigned TGT_TABLE_1   = 11;
  localparam int unsigned TGT_PROC_B_1  = 12;
  localparam int unsigned TGT_PROC_B_2  = 13;
  localparam int unsigned TGT_TABLE_2   = 14;
  localparam int unsigned TGT_PROC_B_3  = 15;
  localparam int unsigned TGT_PROC_B_4  = 16;
  localparam int unsigned TGT_TABLE_3   = 17;
  localparam int unsigned TGT_CUSTOMER  = 18;
  localparam int unsigned TGT_TABLE_4   = 19;
  localparam int unsigned TGT_TABLE_5   = 20;

  // Rule class of a target
  typedef enum logic [2:0] {
    NONE        = 3'd0,
    STORAGE     = 3'd1,
    PROCESSOR_A = 3'd2,
    TABLE       = 3'd3,
    PROCESSOR_B = 3'd4,
    CUSTOMER    = 3'd5
  } target_class_e;

  // Item indices carried in the player's hand
  localparam int unsigned ITEM_NONE       = 0;
  localparam int unsigned ITEM_INGREDIENT = 1;
  localparam int unsigned ITEM_PROCESSED  = 2;
  localparam int unsigned ITEM_DISH       = 3;

endpackage
`default_nettype wire

// File: rtl/operate_target_classifier.sv
`default_nettype none
// ============================================================================
// Module      : operate_target_classifier
// Description : Combinational map of a target index to its rule class.
//               Storages (1..STORAGE_END) take precedence over the fixed map.
// Ports       : target_idx   in  [TARGET_W-1:0] target index
//               target_class out target_class_e  rule class of that target
// Revision    : 1.0 - initial release
// ============================================================================
module operate_target_classifier
  import operate_pkg::*;
#(
  parameter int TARGET_W    = 5,
  parameter int STORAGE_END = 6
) (
  input  logic [TARGET_W-1:0] target_idx,
  output target_class_e       target_class
);

  logic [31:0] idx;
  assign idx = 32'(target_idx);

  always_comb begin
    target_class = NONE;
    if ((idx >= 32'd1) && (idx <= 32'(STORAGE_END))) begin
      target_class = STORAGE;
    end else begin
      case (idx)
        TGT_PROC_A_0, TGT_PROC_A_1:                         target_class = PROCESSOR_A;
        TGT_TABLE_0, TGT_TABLE_1, TGT_TABLE_2,
        TGT_TABLE_3, TGT_TABLE_4, TGT_TABLE_5:              target_class = TABLE;
        TGT_PROC_B_0, TGT_PROC_B_1, TGT_PROC_B_2,
        TGT_PROC_B_3, TGT_PROC_B_4:                         target_class = PROCESSOR_B;
        TGT_CUSTOMER:                                       target_class = CUSTOMER;
        default:                                            target_class = NONE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/operate_verify_seq.sv
`default_nettype none
// ============================================================================
// Module      : operate_verify_seq
// Description : Clocked operate verifier. Accepts one request per handshake,
//               checks it against game state, player feedback and target
//               class, issues a one-cycle verified operate, then waits for
//               the machine-side feedback to settle. Counts delivered dishes.
// Ports       : uart_clk, rst_n (async active-low)
//               op_valid/op_ready          request handshake
//               data_game_state/operate/target, sig_* request + feedback
//               out_valid, data_operate_verified  verified operate pulse
//               data_cusine_finish_num     saturating delivered-dish count
//               timeout_err                sticky WAIT_ACK timeout flag
// Config      : SHADOW_OCCUPANCY_EN - track per-target occupancy internally
//               and use it in place of sig_machine.
// Revision    : 1.0 - initial clocked release
// ============================================================================
module operate_verify_seq
  import operate_pkg::*;
#(
  parameter int TARGET_W    = 5,
  parameter int STORAGE_END = 6,
  parameter int ACK_TIMEOUT = 255,
  parameter int FINISH_W    = 3
) (
  input  logic                uart_clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [7:0]          data_game_state,
  input  logic [7:0]          data_operate,
  input  logic [7:0]          data_target,
  input  logic                sig_front,
  input  logic                sig_hand,
  input  logic                sig_processing,
  input  logic                sig_machine,
  output logic                out_valid,
  output logic [7:0]          data_operate_verified,
  output logic [FINISH_W-1:0] data_cusine_finish_num,
  output logic                timeout_err
);

  localparam int NUM_TARGETS = 2 ** TARGET_W;
  localparam int TIMER_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_ISSUE    = 2'd2;
  localparam logic [1:0] ST_WAIT_ACK = 2'd3;

  logic [1:0]          state_q,    state_d;
  logic [7:0]          op_q,       op_d;
  logic [TARGET_W-1:0] tgt_q,      tgt_d;
  logic                stopped_q,  stopped_d;
  logic                front_q,    front_d;
  logic                hand_q,     hand_d;
  logic                proc_q,     proc_d;
  logic [7:0]          verified_q, verified_d;
  logic                out_valid_q, out_valid_d;
  logic [TIMER_W-1:0]  timer_q,    timer_d;
  logic                tmo_q,      tmo_d;
  logic [FINISH_W-1:0] finish_q,   finish_d;
  logic                mach_eff;

`ifdef SHADOW_OCCUPANCY_EN
  logic [NUM_TARGETS-1:0] occ_q, occ_d;
  assign mach_eff = occ_q[tgt_q];
`else
  logic mach_q, mach_d;
  assign mach_eff = mach_q;
`endif

  // Bits of the input bytes that carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{data_game_state, data_target, sig_machine};

  target_class_e tgt_cls;

  operate_target_classifier #(
    .TARGET_W    (TARGET_W),
    .STORAGE_END (STORAGE_END)
  ) u_classifier (
    .target_idx   (tgt_q),
    .target_class (tgt_cls)
  );

  // Rule evaluation on captured request. MOVE passes every class rule, so
  // the per-class cases only override the MOVE default for other codes;
  // unknown codes (including IGNORE itself) never pass.
  logic       pass;
  logic [7:0] verdict;

  always_comb begin
    pass = (op_q == OP_MOVE);
    case (tgt_cls)
      STORAGE: begin
        if (op_q == OP_GET) pass = !hand_q;
      end
      PROCESSOR_A: begin
        case (op_q)
          OP_GET:      pass = !hand_q && mach_eff;
          OP_PUT:      pass = hand_q && !mach_eff;
          OP_INTERACT: pass = 1'b1;
          default:     ;
        endcase
      end
      TABLE: begin
        case (op_q)
          OP_PUT, OP_THROW: pass = hand_q;
          OP_GET:           pass = !hand_q && mach_eff;
          OP_INTERACT:      pass = 1'b1;
          default:          ;
        endcase
      end
      PROCESSOR_B: begin
        case (op_q)
          OP_PUT:      pass = hand_q && !proc_q;
          OP_GET:      pass = !hand_q && mach_eff;
          OP_INTERACT: pass = 1'b1;
          default:     ;
        endcase
      end
      CUSTOMER: begin
        if (op_q == OP_PUT) pass = hand_q;
      end
      default: ;
    endcase
    if (stopped_q) pass = 1'b0;
    if ((op_q != OP_MOVE) && !front_q) pass = 1'b0;
    verdict = pass ? op_q : OP_IGNORE;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tgt_d       = tgt_q;
    stopped_d   = stopped_q;
    front_d     = front_q;
    hand_d      = hand_q;
    proc_d      = proc_q;
    verified_d  = verified_q;
    out_valid_d = 1'b0;
    timer_d     = timer_q;
    tmo_d       = tmo_q;
    finish_d    = finish_q;
`ifdef SHADOW_OCCUPANCY_EN
    occ_d       = occ_q;
`else
    mach_d      = mach_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d      = data_operate;
          tgt_d     = data_target[TARGET_W+1:2];
          stopped_d = (data_game_state[3:2] == GAME_STATE_STOP);
          front_d   = sig_front;
          hand_d    = sig_hand;
          proc_d    = sig_processing;
`ifndef SHADOW_OCCUPANCY_EN
          mach_d    = sig_machine;
`endif
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        verified_d  = verdict;
        out_valid_d = 1'b1;
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        if ((verified_q == OP_PUT) && (tgt_cls == CUSTOMER) && (finish_q != '1)) begin
          finish_d = finish_q + 1'b1;
        end
`ifdef SHADOW_OCCUPANCY_EN
        if ((verified_q == OP_PUT) && (tgt_cls != CUSTOMER)) occ_d[tgt_q] = 1'b1;
        if (verified_q == OP_GET)                            occ_d[tgt_q] = 1'b0;
`endif
        if (verified_q == OP_IGNORE) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = TIMER_W'(ACK_TIMEOUT);
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // MOVE/INTERACT leave the hand unchanged, so there is nothing to await
        if ((sig_hand != hand_q) || (op_q == OP_MOVE) || (op_q == OP_INTERACT)) begin
          state_d = ST_IDLE;
        end else if (timer_q <= TIMER_W'(1)) begin
          timer_d = '0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_IGNORE;
      tgt_q       <= '0;
      stopped_q   <= 1'b0;
      front_q     <= 1'b0;
      hand_q      <= 1'b0;
      proc_q      <= 1'b0;
      verified_q  <= OP_IGNORE;
      out_valid_q <= 1'b0;
      timer_q     <= '0;
      tmo_q       <= 1'b0;
      finish_q    <= '0;
`ifdef SHADOW_OCCUPANCY_EN
      occ_q       <= '0;
`else
      mach_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tgt_q       <= tgt_d;
      stopped_q   <= stopped_d;
      front_q     <= front_d;
      hand_q      <= hand_d;
      proc_q      <= proc_d;
      verified_q  <= verified_d;
      out_valid_q <= out_valid_d;
      timer_q     <= timer_d;
      tmo_q       <= tmo_d;
      finish_q    <= finish_d;
`ifdef SHADOW_OCCUPANCY_EN
      occ_q       <= occ_d;
`else
      mach_q      <= mach_d;
`endif
    end
  end

  assign op_ready               = (state_q == ST_IDLE);
  assign out_valid              = out_valid_q;
  assign data_operate_verified  = verified_q;
  assign data_cusine_finish_num = finish_q;
  assign timeout_err            = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_operate_verify_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_operate_verify_seq
// Description : Scoreboard bench for operate_verify_seq. Stimulus pushes the
//               hand-computed verified code and accept cycle; a monitor pops
//               and compares on every out_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operate_verify_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] data_game_state;
  logic [7:0] data_operate;
  logic [7:0] data_target;
  logic       sig_front, sig_hand, sig_processing, sig_machine;
  logic       out_valid;
  logic [7:0] data_operate_verified;
  logic [2:0] data_cusine_finish_num;
  logic       timeout_err;

  always #5 clk = ~clk;

  operate_verify_seq #(
    .TARGET_W    (5),
    .STORAGE_END (6),
    .ACK_TIMEOUT (4),
    .FINISH_W    (3)
  ) dut (
    .uart_clk               (clk),
    .rst_n                  (rst_n),
    .op_valid               (op_valid),
    .op_ready               (op_ready),
    .data_game_state        (data_game_state),
    .data_operate           (data_operate),
    .data_target            (data_target),
    .sig_front              (sig_front),
    .sig_hand               (sig_hand),
    .sig_processing         (sig_processing),
    .sig_machine            (sig_machine),
    .out_valid              (out_valid),
    .data_operate_verified  (data_operate_verified),
    .data_cusine_finish_num (data_cusine_finish_num),
    .timeout_err            (timeout_err)
  );

  typedef struct {
    logic [7:0] code;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    int         tgt;
    logic       fr;
    logic       hd;
    logic       pr;
    logic [7:0] ex;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[13];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every verified pulse must match the oldest expectation and
  // appear two cycles after its accept edge.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid actual=%0h required=none", data_operate_verified);
      end else begin
        mon_e = sb.pop_front();
        chk("verified_code", int'(data_operate_verified), int'(mon_e.code));
        chk("issue_latency", cyc - mon_e.cyc, 2);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request, hold it until accepted, and log its expectation.
  // Returns one cycle after the accept edge (DUT in CHECK).
  task automatic send(input logic [7:0] gs, input logic [7:0] op, input int tgt,
                      input logic fr, input logic [7:0] expc);
    int n;
    data_game_state = gs;
    data_operate    = op;
    data_target     = 8'(tgt << 2);
    sig_front       = fr;
    op_valid        = 1'b1;
    n = 0;
    while (!op_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!op_ready) begin
      total++;
      bad++;
      $display("FAIL accept_wait actual=busy required=ready");
    end
    sb.push_back('{code: expc, cyc: cyc});
    tick(1);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!op_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk(name, int'(op_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    op_valid        = 1'b0;
    data_game_state = 8'h00;
    data_operate    = 8'h82;
    data_target     = 8'h00;
    sig_front       = 1'b0;
    sig_hand        = 1'b0;
    sig_processing  = 1'b0;
    sig_machine     = 1'b0;

    vecs[0]  = '{op: 8'h86, tgt: 3,  fr: 1'b0, hd: 1'b0, pr: 1'b0, ex: 8'h82};
    vecs[1]  = '{op: 8'hA2, tgt: 5,  fr: 1'b0, hd: 1'b1, pr: 1'b0, ex: 8'hA2};
    vecs[2]  = '{op: 8'h55, tgt: 9,  fr: 1'b1, hd: 1'b1, pr: 1'b0, ex: 8'h82};
    vecs[3]  = '{op: 8'hC2, tgt: 9,  fr: 1'b1, hd: 1'b1, pr: 1'b0, ex: 8'hC2};
    vecs[4]  = '{op: 8'hC2, tgt: 9,  fr: 1'b1, hd: 1'b0, pr: 1'b0, ex: 8'h82};
    vecs[5]  = '{op: 8'h8A, tgt: 10, fr: 1'b1, hd: 1'b1, pr: 1'b1, ex: 8'h82};
    vecs[6]  = '{op: 8'h8A, tgt: 10, fr: 1'b1, hd: 1'b1, pr: 1'b0, ex: 8'h8A};
    vecs[7]  = '{op: 8'h86, tgt: 21, fr: 1'b1, hd: 1'b0, pr: 1'b0, ex: 8'h82};
    vecs[8]  = '{op: 8'h92, tgt: 2,  fr: 1'b1, hd: 1'b0, pr: 1'b0, ex: 8'h82};
    vecs[9]  = '{op: 8'h86, tgt: 4,  fr: 1'b1, hd: 1'b1, pr: 1'b0, ex: 8'h82};
    vecs[10] = '{op: 8'h92, tgt: 7,  fr: 1'b1, hd: 1'b0, pr: 1'b0, ex: 8'h92};
    vecs[11] = '{op: 8'h86, tgt: 12, fr: 1'b1, hd: 1'b0, pr: 1'b0, ex: 8'h82};
    vecs[12] = '{op: 8'h8A, tgt: 18, fr: 1'b1, hd: 1'b0, pr: 1'b0, ex: 8'h82};

    // Reset values
    #12;
    chk("rst_op_ready",  int'(op_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_verified",  int'(data_operate_verified), 8'h82);
    chk("rst_finish",    int'(data_cusine_finish_num), 0);
    chk("rst_timeout",   int'(timeout_err), 0);
    rst_n = 1'b1;
    tick(1);

    // Stopped game: MOVE ignored, straight back to IDLE
    send(8'h08, 8'hA2, 7, 1'b1, 8'h82);
    tick(1);
    chk("stop_busy_in_issue", int'(op_ready), 0);
    tick(1);
    chk("stop_back_idle", int'(op_ready), 1);

    // GET from storage, hand toggles 4 cycles after accept
    sig_hand = 1'b0;
    send(8'h00, 8'h86, 3, 1'b1, 8'h86);
    tick(3);
    chk("get_waiting_ack", int'(op_ready), 0);
    sig_hand = 1'b1;
    tick(1);
    chk("get_idle_after_hand", int'(op_ready), 1);

    // PUT to processor A: machine empty passes, machine busy ignored
    sig_hand    = 1'b1;
    sig_machine = 1'b0;
    send(8'h00, 8'h8A, 8, 1'b1, 8'h8A);
    sig_hand = 1'b0;
    wait_idle("proca_put_idle");
    sig_hand    = 1'b1;
    sig_machine = 1'b1;
    send(8'h00, 8'h8A, 8, 1'b1, 8'h82);
    tick(2);
    chk("proca_ignored_idle", int'(op_ready), 1);
    sig_machine = 1'b0;

    // Directed rule vectors
    for (int i = 0; i < 13; i++) begin
      sig_hand       = vecs[i].hd;
      sig_processing = vecs[i].pr;
      send(8'h00, vecs[i].op, vecs[i].tgt, vecs[i].fr, vecs[i].ex);
      if (vecs[i].ex != 8'h82) sig_hand = ~sig_hand;
      wait_idle("vector_idle");
    end
    sig_processing = 1'b0;
    chk("finish_untouched", int'(data_cusine_finish_num), 0);

    // Deliveries to the customer: count saturates at 7
    for (int i = 0; i < 9; i++) begin
      sig_hand = 1'b1;
      send(8'h00, 8'h8A, 18, 1'b1, 8'h8A);
      sig_hand = 1'b0;
      wait_idle("customer_idle");
      chk("finish_count", int'(data_cusine_finish_num), (i < 7) ? i + 1 : 7);
    end

    // Timeout: hand never changes
    chk("timeout_clear_before", int'(timeout_err), 0);
    sig_hand = 1'b0;
    send(8'h00, 8'h86, 3, 1'b1, 8'h86);
    tick(5);
    chk("timeout_still_waiting", int'(op_ready), 0);
    chk("timeout_not_yet", int'(timeout_err), 0);
    tick(1);
    chk("timeout_idle", int'(op_ready), 1);
    chk("timeout_set", int'(timeout_err), 1);

    // Asynchronous reset in the middle of WAIT_ACK
    send(8'h00, 8'h86, 3, 1'b1, 8'h86);
    tick(2);
    chk("pre_reset_waiting", int'(op_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_op_ready",  int'(op_ready), 1);
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_verified",  int'(data_operate_verified), 8'h82);
    chk("async_rst_finish",    int'(data_cusine_finish_num), 0);
    chk("async_rst_timeout",   int'(timeout_err), 0);
    #3;
    rst_n = 1'b1;
    tick(2);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operate_verify_seq.md
Name: operate_verify_seq

Overview:
- Clocked, parametrised successor to the combinational operate verifier; sits between the UART command decoder and the operate transmitter.
- Accepts one operate request per handshake and checks it against game state, player feedback and a per-target rule class.
- Issues a registered verified operate, then waits for the machine-side feedback to settle before accepting the next request.
- Keeps a saturating count of dishes delivered to customers.

Parameters:
- TARGET_W, 5, width of target index (data_target[TARGET_W+1:2]); NUM_TARGETS = 2**TARGET_W.
- STORAGE_END, 6, targets 1..STORAGE_END are storages.
- ACK_TIMEOUT, 255, max cycles in WAIT_ACK before forced return to IDLE.
- FINISH_W, 3, width of delivered-dish counter.

Ports:
- uart_clk in 1 clock
- rst_n in 1 asynchronous active-low reset
- op_valid in 1 request strobe
- op_ready out 1 block can accept request
- data_game_state in 8 game state byte; [3:2]==2'b10 means stopped
- data_operate in 8 raw operate code
- data_target in 8 target byte
- sig_front, sig_hand, sig_processing, sig_machine in 1 each, player/machine feedback
- out_valid out 1 one-cycle pulse, verified operate present
- data_operate_verified out 8 verified operate code
- data_cusine_finish_num out FINISH_W delivered-dish count
- timeout_err out 1 sticky, WAIT_ACK timed out

Behaviour:
- Codes: GET 8'h86, PUT 8'h8A, INTERACT 8'h92, MOVE 8'hA2, THROW 8'hC2, IGNORE 8'h82. Any other code is treated as IGNORE.
- Reset (async, rst_n low): state IDLE, op_ready 1, out_valid 0, data_operate_verified 8'h82, finish count 0, timeout_err 0, timer 0.
- FSM:
  - IDLE: op_ready=1. On op_valid, capture operate, target and all sig_* into registers; go to CHECK.
  - CHECK: op_ready=0. Evaluate the rules below on the captured values; go to ISSUE.
  - ISSUE: drive out_valid=1 with the verified code for exactly one cycle. If the result is IGNORE, go to IDLE; otherwise load timer and go to WAIT_ACK.
  - WAIT_ACK: exit to IDLE the first cycle that live sig_hand differs from the captured sig_hand, or that the op was MOVE/INTERACT, or when the timer hits 0. Timer exit sets timeout_err; it clears only on reset.
- Latency: request accepted in IDLE, verified output 2 cycles later.
- Rules, applied in order, first match wins:
  1. Game stopped -> IGNORE.
  2. Op is not MOVE and sig_front=0 -> IGNORE.
  3. Per target class:
     - STORAGE: GET needs hand=0; PUT, THROW and INTERACT -> IGNORE.
     - PROCESSOR_A (7, 8): THROW -> IGNORE; PUT needs hand=1 and machine=0; GET needs hand=0 and machine=1.
     - TABLE (9, 11, 14, 17, 19, 20): PUT and THROW need hand=1; GET needs hand=0 and machine=1.
     - PROCESSOR_B (10, 12, 13, 15, 16): THROW -> IGNORE; PUT needs hand=1; GET needs hand=0 and machine=1; PUT additionally rejected while sig_processing=1.
     - CUSTOMER (18): only PUT with hand=1, or MOVE, passes.
     - NONE (0, 21..NUM_TARGETS-1): IGNORE.
  4. MOVE always passes rule 3.
- Finish count: increments on ISSUE of a verified PUT to CUSTOMER; saturates at all-ones.
- op_valid outside IDLE is dropped; the source must hold it until it sees op_ready.
- Reset mid-WAIT_ACK: immediate return to IDLE; counters cleared.

Optional Feature:
- Macro SHADOW_OCCUPANCY_EN.
- Defined: block keeps a NUM_TARGETS-bit occupancy register, reset to 0.
  - A verified PUT to a non-customer, non-trash target sets its bit.
  - A verified GET clears its bit.
  - All machine=... checks use this bit instead of sig_machine.
- Undefined: sig_machine is used directly; no register is built.

Decomposition:
- Package operate_pkg holds:
  - operate code constants
  - GAME_STATE_STOP
  - target index constants
  - target-class enum {NONE, STORAGE, PROCESSOR_A, TABLE, PROCESSOR_B, CUSTOMER}
  - item index constants
- One sub-module, operate_target_classifier: combinational map of target index to class, parametrised by TARGET_W and STORAGE_END.

Test Plan:
- Game state 8'h08 (stopped), MOVE to target 7 -> out_valid 2 cycles after accept, verified 8'h82, straight back to IDLE.
- front=1, hand=0, GET to target 3 -> 8'h86; hand toggles 4 cycles later -> IDLE, op_ready=1 next cycle.
- front=1, hand=1, machine=0, PUT to target 8 -> 8'h8A; same request with machine=1 -> 8'h82.
- PUT to customer 18 with hand=1, repeated 9 times with hand toggling -> finish count reads 1..7, then stays 7.
- ACK_TIMEOUT=4, verified GET, hand never changes -> IDLE after 4 WAIT_ACK cycles, timeout_err=1.
- Reset asserted during WAIT_ACK -> outputs return to reset values asynchronously, before the next edge.
